// File: rtl/bus_master_port_pkg.sv
// Shared serial-bus definitions: phase encoding, mode bit values and default widths
// used by the master port, address decoder and slave ports.
package bus_master_port_pkg;

  localparam int DEV_ADDR_W     = 4;
  localparam int MEM_ADDR_W     = 12;
  localparam int DATA_W         = 8;
  localparam int RD_TIMEOUT_DEF = 16;

  localparam logic MODE_WRITE = 1'b1;
  localparam logic MODE_READ  = 1'b0;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DEV_ADDR = 3'd1,
    ACK_CHK  = 3'd2,
    FRAME    = 3'd3,
    RD_WAIT  = 3'd4,
    RD_DATA  = 3'd5,
    DONE     = 3'd6,
    ERR      = 3'd7
  } state_t;

  // One counter covers the longest phase: mode + address + data, plus one spare bit.
  function automatic int bit_cnt_w(input int mem_aw, input int dw);
    return $clog2(1 + mem_aw + dw + 1);
  endfunction

endpackage

// File: rtl/bus_shift_tx.sv
// Loadable LSB-first parallel-to-serial shifter with bit counter and last-bit flag.
// next_bit is the bit for the coming cycle (same-cycle view on load); no backpressure, shift only when told.
module bus_shift_tx #(
  parameter int W  = 21,
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          load,
  input  logic          shift,
  input  logic [W-1:0]  data,
  input  logic [CW-1:0] len,
  output logic          next_bit,
  output logic          last
);

  logic [W-1:0]  sr;
  logic [CW-1:0] cnt;
  logic [CW-1:0] len_q;

  // sr holds only the bits not yet placed on the bus; bit 0 leaves on load.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sr    <= '0;
      cnt   <= '0;
      len_q <= '0;
    end else if (load) begin
      sr    <= data >> 1;
      cnt   <= '0;
      len_q <= len;
    end else if (shift) begin
      sr  <= sr >> 1;
      cnt <= cnt + 1'b1;
    end
  end

  assign next_bit = load ? data[0] : sr[0];
  assign last     = (cnt == len_q - 1'b1);

endmodule

// File: rtl/bus_master_port.sv
// Serial bus master: device address, decoder ack check, mode/address/data frame, optional read-back.
// Write done N+M+D+3 cycles after acceptance, read adds the slave wait; req_ready low while busy, req is not queued.
module bus_master_port
  import bus_master_port_pkg::*;
#(
  parameter int DEVICE_ADDR_WIDTH = DEV_ADDR_W,
  parameter int MEM_ADDR_WIDTH    = MEM_ADDR_W,
  parameter int DATA_WIDTH        = DATA_W,
  parameter int RD_TIMEOUT        = RD_TIMEOUT_DEF
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         req,
  input  logic                         req_write,
  input  logic [DEVICE_ADDR_WIDTH-1:0] req_dev,
  input  logic [MEM_ADDR_WIDTH-1:0]    req_addr,
  input  logic [DATA_WIDTH-1:0]        req_wdata,
  output logic                         req_ready,
  output logic                         mvalid,
  output logic                         mwdata,
  input  logic                         ack,
  input  logic                         svalid,
  input  logic                         srdata,
  output logic [DATA_WIDTH-1:0]        rdata,
  output logic                         done,
  output logic                         err
);

  localparam int FRAME_W = 1 + MEM_ADDR_WIDTH + DATA_WIDTH;
  localparam int CW      = bit_cnt_w(MEM_ADDR_WIDTH, DATA_WIDTH);
  localparam int TW      = $clog2(RD_TIMEOUT + 1);

  state_t                state;
  logic                  is_wr;
  logic [FRAME_W-1:0]    frame;
  logic [TW-1:0]         tcnt;
  logic [DATA_WIDTH-2:0] rsh;
  logic [DATA_WIDTH-1:0] rx_word;

  logic               tx_load;
  logic               tx_shift;
  logic [FRAME_W-1:0] tx_data;
  logic [CW-1:0]      tx_len;
  logic               tx_next;
  logic               tx_last;

  bus_shift_tx #(.W(FRAME_W), .CW(CW)) u_tx (
    .clk      (clk),
    .rstn     (rstn),
    .load     (tx_load),
    .shift    (tx_shift),
    .data     (tx_data),
    .len      (tx_len),
    .next_bit (tx_next),
    .last     (tx_last)
  );

  assign rx_word   = {srdata, rsh};
  assign req_ready = (state == IDLE);

  // During the read word the shifter acts purely as the bit counter; bit 0
  // arrives with the load, so DATA_WIDTH-1 further bits remain.
  always_comb begin
    tx_load  = 1'b0;
    tx_shift = 1'b0;
    tx_data  = '0;
    tx_len   = '0;
    case (state)
      IDLE: if (req) begin
        tx_load = 1'b1;
        tx_data = FRAME_W'(req_dev);
        tx_len  = CW'(DEVICE_ADDR_WIDTH);
      end
      DEV_ADDR, FRAME: tx_shift = !tx_last;
      ACK_CHK: if (ack) begin
        tx_load = 1'b1;
        tx_data = frame;
        tx_len  = is_wr ? CW'(FRAME_W) : CW'(1 + MEM_ADDR_WIDTH);
      end
      RD_WAIT: if (svalid) begin
        tx_load = 1'b1;
        tx_len  = CW'(DATA_WIDTH - 1);
      end
      RD_DATA: tx_shift = svalid && !tx_last;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      mvalid <= 1'b0;
      mwdata <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      rdata  <= '0;
      is_wr  <= 1'b0;
      frame  <= '0;
      tcnt   <= '0;
      rsh    <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: if (req) begin
          frame  <= {req_wdata, req_addr, req_write};
          is_wr  <= (req_write == MODE_WRITE);
          mvalid <= 1'b1;
          mwdata <= tx_next;
          state  <= DEV_ADDR;
        end
        DEV_ADDR: begin
          mwdata <= tx_last ? 1'b0 : tx_next;
          if (tx_last) state <= ACK_CHK;
        end
        ACK_CHK: if (ack) begin
          mwdata <= tx_next;
          state  <= FRAME;
        end else begin
          // Drop mvalid right away so the decoder does not start a new address capture.
          mvalid <= 1'b0;
          mwdata <= 1'b0;
          done   <= 1'b1;
          err    <= 1'b1;
          state  <= ERR;
        end
        FRAME: if (!tx_last) begin
          mwdata <= tx_next;
        end else if (is_wr) begin
          mvalid <= 1'b0;
          mwdata <= 1'b0;
          done   <= 1'b1;
          state  <= DONE;
        end else begin
          mwdata <= 1'b0;
          tcnt   <= '0;
          state  <= RD_WAIT;
        end
        RD_WAIT: if (svalid) begin
          rsh   <= rx_word[DATA_WIDTH-1:1];
          state <= RD_DATA;
        end else if (tcnt == TW'(RD_TIMEOUT - 1)) begin
          mvalid <= 1'b0;
          done   <= 1'b1;
          err    <= 1'b1;
          state  <= ERR;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
        RD_DATA: if (!svalid) begin
          mvalid <= 1'b0;
          done   <= 1'b1;
          err    <= 1'b1;
          state  <= ERR;
        end else begin
          rsh <= rx_word[DATA_WIDTH-1:1];
          if (tx_last) begin
            rdata  <= rx_word;
            mvalid <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE, ERR: state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_master_port.sv
// Bench for bus_master_port: directed table, reset/hold corner cases and random transactions
// checked cycle by cycle against an expected bus bit stream built from the protocol rules.
module tb_bus_master_port;

  localparam int N   = 4;
  localparam int M   = 12;
  localparam int D   = 8;
  localparam int TO  = 16;
  localparam int RWS = N + 3 + M;  // first RD_WAIT cycle after acceptance

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         req = 1'b0;
  logic         req_write = 1'b0;
  logic [N-1:0] req_dev = '0;
  logic [M-1:0] req_addr = '0;
  logic [D-1:0] req_wdata = '0;
  logic         req_ready;
  logic         mvalid;
  logic         mwdata;
  logic         ack = 1'b0;
  logic         svalid = 1'b0;
  logic         srdata = 1'b0;
  logic [D-1:0] rdata;
  logic         done;
  logic         err;

  always #5 clk = ~clk;

  bus_master_port #(
    .DEVICE_ADDR_WIDTH(N), .MEM_ADDR_WIDTH(M), .DATA_WIDTH(D), .RD_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rstn(rstn), .req(req), .req_write(req_write), .req_dev(req_dev),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .mvalid(mvalid), .mwdata(mwdata), .ack(ack), .svalid(svalid), .srdata(srdata),
    .rdata(rdata), .done(done), .err(err)
  );

  typedef struct {
    bit         wr;
    bit [N-1:0] dev;
    bit [M-1:0] addr;
    bit [D-1:0] wdata;
    bit         ackv;
    int         wt;      // idle cycles in RD_WAIT before svalid
    bit [D-1:0] rword;
    int         nbits;   // valid bits the slave sends before dropping svalid
    int         lat;     // acceptance-to-done cycles
    bit         eerr;
    bit [D-1:0] erdata;
  } rec_t;

  int vectors = 0;
  int miscompares = 0;
  logic [D-1:0] model_rdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic rec_t mk(input bit wr, input bit [N-1:0] dev, input bit [M-1:0] addr,
                              input bit [D-1:0] wd, input bit ackv, input int wt,
                              input bit [D-1:0] rw, input int nb, input int lat,
                              input bit eerr, input bit [D-1:0] erd);
    rec_t r;
    r.wr = wr; r.dev = dev; r.addr = addr; r.wdata = wd; r.ackv = ackv; r.wt = wt;
    r.rword = rw; r.nbits = nb; r.lat = lat; r.eerr = eerr; r.erdata = erd;
    return r;
  endfunction

  // Reference outcome of a transaction from the protocol timing rules.
  function automatic rec_t fill(input rec_t r);
    r.eerr   = 1'b1;
    r.erdata = model_rdata;
    if (!r.ackv) r.lat = N + 2;
    else if (r.wr) begin r.lat = N + 2 + M + D + 1; r.eerr = 1'b0; end
    else if (r.wt >= TO) r.lat = RWS + TO;
    else if (r.nbits < D) r.lat = RWS + r.wt + r.nbits + 1;
    else begin r.lat = RWS + r.wt + D; r.eerr = 1'b0; r.erdata = r.rword; end
    return r;
  endfunction

  function automatic rec_t rand_rec();
    rec_t r;
    r.wr    = 1'($urandom);
    r.dev   = N'($urandom);
    r.addr  = M'($urandom);
    r.wdata = D'($urandom);
    r.ackv  = ($urandom_range(0, 7) != 0);
    r.wt    = $urandom_range(0, TO + 1);
    r.rword = D'($urandom);
    r.nbits = ($urandom_range(0, 3) == 0) ? $urandom_range(1, D - 1) : D;
    return fill(r);
  endfunction

  // Call just after a negedge with the DUT idle in the coming cycle (cycle A).
  task automatic run_txn(input rec_t r, input bit hold, input int abort_c, input int id);
    bit q[$];
    int qs, k;
    logic [4:0] e, a;
    for (int i = 0; i < N; i++) q.push_back(r.dev[i]);
    q.push_back(1'b0);
    if (r.ackv) begin
      q.push_back(r.wr);
      for (int i = 0; i < M; i++) q.push_back(r.addr[i]);
      if (r.wr) for (int i = 0; i < D; i++) q.push_back(r.wdata[i]);
    end
    qs = q.size();
    chk($sformatf("t%0d req_ready at accept", id), {31'd0, req_ready}, 32'd1);
    req = 1'b1; req_write = r.wr; req_dev = r.dev; req_addr = r.addr; req_wdata = r.wdata;
    ack = !r.ackv; svalid = 1'($urandom); srdata = 1'($urandom);
    for (int c = 1; c <= r.lat; c++) begin
      @(negedge clk);
      e = {c < r.lat, (c - 1 < qs) ? q[c-1] : 1'b0, c == r.lat, (c == r.lat) && r.eerr, 1'b0};
      a = {mvalid, mwdata, done, err, req_ready};
      chk($sformatf("t%0d c%0d {mvalid,mwdata,done,err,req_ready}", id, c), 32'(a), 32'(e));
      if (c == r.lat) chk($sformatf("t%0d rdata", id), 32'(rdata), 32'(r.erdata));
      if (c == abort_c) begin
        #2 rstn = 1'b0;
        #1 chk($sformatf("t%0d async reset {mvalid,done,err,req_ready}", id),
               32'({mvalid, done, err, req_ready}), 32'h1);
        @(negedge clk);
        rstn = 1'b1; req = 1'b0;
        return;
      end
      req = hold;
      req_write = 1'($urandom); req_dev = N'($urandom);
      req_addr = M'($urandom); req_wdata = D'($urandom);
      ack = (c == N + 1) ? r.ackv : !r.ackv;
      if (!r.wr && r.ackv && c >= RWS) begin
        k = c - RWS - r.wt;
        svalid = (r.wt < TO) && (k >= 0) && (k < r.nbits);
        srdata = (k >= 0 && k < D) ? r.rword[k] : 1'($urandom);
      end else begin
        svalid = 1'($urandom);
        srdata = 1'($urandom);
      end
    end
    model_rdata = r.erdata;
  endtask

  task automatic idle_check(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk($sformatf("%s idle%0d {mvalid,mwdata,done,err,req_ready}", tag, i),
          32'({mvalid, mwdata, done, err, req_ready}), 32'h1);
      req = 1'b0; ack = 1'($urandom); svalid = 1'($urandom);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rec_t tbl[8];
    rec_t r;
    tbl[0] = mk(1, 4'h2, 12'h0A5, 8'h3C, 1, 0,  8'h00, D, 27, 0, 8'h00);
    tbl[1] = mk(0, 4'h1, 12'h010, 8'h00, 1, 3,  8'hA7, D, 30, 0, 8'hA7);
    tbl[2] = mk(0, 4'h3, 12'h123, 8'h55, 0, 0,  8'h00, D, 6,  1, 8'hA7);
    tbl[3] = mk(0, 4'h5, 12'h2F0, 8'h00, 1, 16, 8'hFF, D, 35, 1, 8'hA7);
    tbl[4] = mk(0, 4'h6, 12'h7FF, 8'h00, 1, 0,  8'h55, 5, 25, 1, 8'hA7);
    tbl[5] = mk(0, 4'h9, 12'h001, 8'h00, 1, 15, 8'h3E, D, 42, 0, 8'h3E);
    tbl[6] = mk(1, 4'hF, 12'hABC, 8'h81, 0, 0,  8'h00, D, 6,  1, 8'h3E);
    tbl[7] = mk(1, 4'hE, 12'hFFF, 8'hFF, 1, 0,  8'h00, D, 27, 0, 8'h3E);

    repeat (3) @(negedge clk);
    chk("reset {mvalid,mwdata,done,err,req_ready}",
        32'({mvalid, mwdata, done, err, req_ready}), 32'h1);
    chk("reset rdata", 32'(rdata), 32'h0);
    rstn = 1'b1;
    idle_check(2, "post-reset");

    for (int i = 0; i < 8; i++) begin
      run_txn(tbl[i], 1'b0, -1, i);
      idle_check(1, $sformatf("t%0d", i));
    end

    // Reset in the middle of a write frame, then a normal write.
    r = mk(1, 4'h7, 12'h5A5, 8'hC3, 1, 0, 8'h00, D, 27, 0, 8'h00);
    run_txn(r, 1'b0, 12, 100);
    model_rdata = '0;
    idle_check(4, "after-abort");
    run_txn(tbl[0], 1'b0, -1, 101);
    idle_check(1, "t101");

    // req held high: one transaction per acceptance, next one only once idle.
    r = rand_rec();
    r.ackv = 1'b1; r.wr = 1'b1;
    r = fill(r);
    run_txn(r, 1'b1, -1, 102);
    @(negedge clk);
    r = rand_rec();
    run_txn(r, 1'b0, -1, 103);
    idle_check(3, "after-hold");

    for (int i = 0; i < 40; i++) begin
      r = rand_rec();
      run_txn(r, 1'b0, -1, 200 + i);
      idle_check(1, $sformatf("t%0d", 200 + i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bus_master_port.md
Name: bus_master_port

Overview:
- Master-side initiator of the serial system bus.
- Accepts a parallel request from a local master: target device, memory address, write data, direction.
- Serializes the device address LSB-first on mwdata/mvalid toward the address decoder and checks the decoder's ack.
- Then sends a mode/address/data frame to the selected slave and, for reads, deserializes the returned data.

Parameters:
- DEVICE_ADDR_WIDTH, 4: device-select bits sent first.
- MEM_ADDR_WIDTH, 12: slave memory address bits.
- DATA_WIDTH, 8: data word width.
- RD_TIMEOUT, 16: maximum cycles to wait for the first svalid on a read.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- req  in  1  request strobe from local master.
- req_write  in  1  1 = write, 0 = read.
- req_dev  in  DEVICE_ADDR_WIDTH  target device address.
- req_addr  in  MEM_ADDR_WIDTH  slave memory address.
- req_wdata  in  DATA_WIDTH  write data.
- req_ready  out  1  block idle, can accept req.
- mvalid  out  1  bus valid toward decoder/slave.
- mwdata  out  1  serial write data bus.
- ack  in  1  decoder acknowledge (combinational, valid in its connect cycle).
- svalid  in  1  slave read-data valid.
- srdata  in  1  serial read data, LSB first.
- rdata  out  DATA_WIDTH  last read word.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle error pulse, coincident with done.

Behaviour:
- Clock and reset: one clock clk; reset rstn asynchronous, active-low.
- Reset values: mvalid=0, mwdata=0, done=0, err=0, rdata=0, req_ready=1, state=IDLE. All outputs registered except req_ready = (state==IDLE).
- Reset mid-transaction aborts immediately. mvalid drops asynchronously; no done/err is generated.
- IDLE: req&req_ready in cycle A captures all req_* fields.
- DEV_ADDR, cycles A+1..A+N (N=DEVICE_ADDR_WIDTH): mvalid=1, mwdata=req_dev[i] in cycle A+1+i.
- ACK_CHK, cycle A+N+1: mvalid=1, mwdata=0, ack sampled.
  - ack=1 -> FRAME.
  - ack=0 -> ERR. Decoder has rejected the address; mvalid must be 0 in cycle A+N+2 so the decoder does not restart address capture.
- FRAME: mvalid=1, serial bits LSB-first in consecutive cycles.
  - First bit: mode (req_write).
  - Then MEM_ADDR_WIDTH address bits.
  - Then, for writes only, DATA_WIDTH data bits.
  - Write: after the last bit -> DONE.
  - Read: after the last address bit -> RD_WAIT.
- RD_WAIT: mvalid=1, mwdata=0; wait counter runs.
  - svalid=1 -> RD_DATA, taking that cycle's srdata as bit0.
  - RD_TIMEOUT cycles without svalid -> ERR.
- RD_DATA: shift in srdata on DATA_WIDTH consecutive svalid cycles, LSB first.
  - svalid low before the word completes -> ERR; rdata unchanged.
  - On the final bit, rdata updates in the same clock edge that enters DONE.
- DONE: mvalid=0, done=1 for one cycle -> IDLE.
- ERR: mvalid=0, done=1, err=1 for one cycle -> IDLE.
- Ignored inputs:
  - req outside IDLE is ignored (no queueing).
  - ack outside ACK_CHK is ignored.
  - svalid outside RD_WAIT/RD_DATA is ignored.
- Bit counter: single counter sized $clog2(1+MEM_ADDR_WIDTH+DATA_WIDTH+1), reused per phase, cleared on each phase entry. The timeout counter is separate; it saturates and never wraps.
- Latency, from acceptance cycle A to done:
  - write: N + 2 + MEM_ADDR_WIDTH + DATA_WIDTH + 1 cycles.
  - read: N + 2 + MEM_ADDR_WIDTH + wait + DATA_WIDTH + 1 cycles.

Decomposition:
- Shared bus package:
  - state encoding localparams (IDLE, DEV_ADDR, ACK_CHK, FRAME, RD_WAIT, RD_DATA, DONE, ERR);
  - MODE_WRITE=1, MODE_READ=0;
  - default widths, shared with the address decoder and slave ports.
- One natural sub-module: bus_shift_tx, a loadable LSB-first parallel-to-serial shifter with bit counter and last-bit flag. It is used for both the device-address and frame phases. Read deserialization stays inline.

Test Plan:
- Write, dev=2, addr=0x0A5, wdata=0x3C, ack=1 in ACK_CHK:
  - mwdata dev bits 0,1,0,0; then mode 1; then addr bits 1,0,1,0,0,1,0,1,0,0,0,0; then data bits 0,0,1,1,1,1,0,0.
  - mvalid high throughout.
  - done at A+27, err=0.
- Read, dev=1, addr=0x010; slave asserts svalid 3 cycles into RD_WAIT with srdata bits for 0xA7 LSB first:
  - rdata=0xA7, done=1, err=0, mvalid low in the done cycle.
- Invalid device, dev=3, ack=0 in ACK_CHK:
  - mvalid=0 at A+6; done=1 and err=1 at A+6; no frame bits emitted; req_ready=1 at A+7.
- Read with no svalid for 16 cycles:
  - err=1 with done; rdata keeps its previous value (0xA7).
- rstn pulsed low in the middle of FRAME:
  - mvalid=0 immediately (asynchronously), no done/err, req_ready=1.
  - A new write request afterwards completes normally.
- req held high during a busy transaction:
  - exactly one transaction per IDLE acceptance.
  - a second req accepted only once req_ready=1 again.
